// File: rtl/serial_bus_arbiter_if.sv
// Bus bundle between N masters, the arbiter and N slaves. The slave modport is the arbiter's
// view (it serves the master requests); the master modport is the view of the attached agents.
interface serial_bus_arbiter_if #(
  parameter int N_MASTERS = 2,
  parameter int N_SLAVES  = 3
);
  logic [N_MASTERS-1:0] m_request, m_address, m_data, m_valid, m_write_en;
  logic [N_MASTERS-1:0] m_grant, m_ready, m_data_out, m_valid_in, m_error;
  logic [N_SLAVES-1:0]  s_ready, s_data_in, s_valid_out;
  logic [N_SLAVES-1:0]  s_address, s_data, s_valid, s_write_en;
  logic [2:0]           state;

  modport slave (
    input  m_request, m_address, m_data, m_valid, m_write_en,
    input  s_ready, s_data_in, s_valid_out,
    output m_grant, m_ready, m_data_out, m_valid_in, m_error,
    output s_address, s_data, s_valid, s_write_en, state
  );

  modport master (
    output m_request, m_address, m_data, m_valid, m_write_en,
    output s_ready, s_data_in, s_valid_out,
    input  m_grant, m_ready, m_data_out, m_valid_in, m_error,
    input  s_address, s_data, s_valid, s_write_en, state
  );
endinterface

// File: rtl/serial_bus_arbiter.sv
// Multi-master serial bus arbiter: grants one master, collects a serial slave address, then
// connects master and slave; a stalled slave lets a waiting master pre-empt via a split.
module serial_bus_arbiter #(
  parameter int N_MASTERS     = 2,
  parameter int N_SLAVES      = 3,
  parameter int ADDR_BITS     = 2,
  parameter int SPLIT_TIMEOUT = 4,
  parameter int RR_MODE       = 1
) (
  input logic                 clk,
  input logic                 reset,
  serial_bus_arbiter_if.slave bus
);
  localparam int MW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int CW = $clog2(ADDR_BITS + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    CONNECT = 3'd2,
    BUSY    = 3'd3,
    SWITCH  = 3'd4
  } state_t;

  typedef struct packed {
    logic          found;
    logic [MW-1:0] idx;
  } win_t;

  state_t               state_q, state_d, prev_q, prev_d;
  logic [N_MASTERS-1:0] grant_q, grant_d, split_q, split_d;
  logic [MW-1:0]        last_q, last_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d, sel_q, sel_d;
  logic [CW-1:0]        bit_q, bit_d;
  logic [3:0]           busy_q, busy_d;

  logic [N_MASTERS-1:0] excl, others, win_oh;
  logic [N_SLAVES-1:0]  addr_oh, sel_oh, route_oh;
  logic                 req_g, valid_g, addr_bit, bad_addr, addr_ready, sel_ready, timeout, in_busy;
  win_t                 win;

  // Round-robin scans upward from the last granted index; fixed priority scans from index 0.
  function automatic win_t pick_one(input logic [N_MASTERS-1:0] cand, input logic [MW-1:0] last);
    win_t                 w;
    int                   j;
    logic [N_MASTERS-1:0] rot;
    w = '0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      j   = (RR_MODE != 0) ? (int'(last) + k) % N_MASTERS : k - 1;
      rot = cand >> j;
      if (!w.found && rot[0]) begin
        w.found = 1'b1;
        w.idx   = MW'(j);
      end
    end
    return w;
  endfunction

  function automatic win_t arbitrate(input logic [N_MASTERS-1:0] cand,
                                     input logic [N_MASTERS-1:0] split,
                                     input logic [MW-1:0]        last);
    return (|(cand & split)) ? pick_one(cand & split, last) : pick_one(cand, last);
  endfunction

  assign req_g    = |(bus.m_request & grant_q);
  assign valid_g  = |(bus.m_valid & grant_q);
  assign addr_bit = |(bus.m_address & grant_q);
  assign others   = bus.m_request & ~grant_q;

  // A shifted one-hot drops to zero exactly when the index is past the last slave.
  assign addr_oh    = N_SLAVES'(1) << addr_q;
  assign sel_oh     = N_SLAVES'(1) << sel_q;
  assign bad_addr   = (addr_oh == '0);
  assign addr_ready = |(bus.s_ready & addr_oh);
  assign sel_ready  = |(bus.s_ready & sel_oh);
  assign timeout    = (busy_q >= 4'(SPLIT_TIMEOUT));

  assign excl   = (state_q == SWITCH) ? grant_q : '0;
  assign win    = arbitrate(bus.m_request & ~excl, split_q, last_q);
  assign win_oh = N_MASTERS'(1) << win.idx;

  always_comb begin
    // NOTE: every variable gets a default before the case, so no path can infer a latch.
    state_d = state_q;
    prev_d  = prev_q;
    grant_d = grant_q;
    split_d = split_q;
    last_d  = last_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    bit_d   = bit_q;
    busy_d  = 4'd0;
    if (((state_q == CONNECT) && !addr_ready) || ((state_q == BUSY) && !sel_ready))
      busy_d = (busy_q == 4'd15) ? busy_q : busy_q + 4'd1;

    case (state_q)
      IDLE: if (win.found) begin
        grant_d = win_oh;
        last_d  = win.idx;
        split_d = split_q & ~win_oh;
        bit_d   = '0;
        state_d = ADDR;
      end
      ADDR: if (!req_g) begin
        grant_d = '0;
        state_d = IDLE;
      end else if (valid_g) begin
        addr_d = ADDR_BITS'({addr_q, addr_bit});
        bit_d  = bit_q + CW'(1);
        if (bit_q == CW'(ADDR_BITS - 1)) state_d = CONNECT;
      end
      CONNECT: if (bad_addr) begin
        grant_d = '0;
        state_d = IDLE;
      end else if (addr_ready) begin
        sel_d   = addr_q;
        state_d = BUSY;
      end else if (timeout && |others) begin
        prev_d  = CONNECT;
        state_d = SWITCH;
      end
      BUSY: if (!req_g) begin
        grant_d = '0;
        state_d = IDLE;
      end else if (timeout && |others) begin
        prev_d  = BUSY;
        state_d = SWITCH;
      end
      SWITCH: if (win.found) begin
        split_d = (split_q | grant_q) & ~win_oh;
        grant_d = win_oh;
        last_d  = win.idx;
        bit_d   = '0;
        state_d = ADDR;
      end else begin
        state_d = prev_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      prev_q  <= IDLE;
      grant_q <= '0;
      split_q <= '0;
      last_q  <= MW'(N_MASTERS - 1);
      addr_q  <= '0;
      sel_q   <= '0;
      bit_q   <= '0;
      busy_q  <= 4'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      prev_q  <= prev_d;
      grant_q <= grant_d;
      split_q <= split_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      bit_q   <= bit_d;
      busy_q  <= busy_d;
    end
  end

  // Slave routing and return paths exist only while connected, so address bits never leak.
  assign in_busy  = (state_q == BUSY);
  assign route_oh = in_busy ? sel_oh : '0;

  assign bus.s_address  = route_oh & {N_SLAVES{addr_bit}};
  assign bus.s_data     = route_oh & {N_SLAVES{|(bus.m_data & grant_q)}};
  assign bus.s_valid    = route_oh & {N_SLAVES{valid_g}};
  assign bus.s_write_en = route_oh & {N_SLAVES{|(bus.m_write_en & grant_q)}};

  assign bus.m_ready    = in_busy ? (grant_q & {N_MASTERS{sel_ready}}) : '0;
  assign bus.m_data_out = in_busy ? (grant_q & {N_MASTERS{|(bus.s_data_in & sel_oh)}}) : '0;
  assign bus.m_valid_in = in_busy ? (grant_q & {N_MASTERS{|(bus.s_valid_out & sel_oh)}}) : '0;
  assign bus.m_error    = ((state_q == CONNECT) && bad_addr) ? grant_q : '0;
  assign bus.m_grant    = grant_q;
  assign bus.state      = state_q;
endmodule
